// File: rtl/rf_write_arbiter.sv
// Round-robin arbiter for the single register-file write port.
// One grant per cycle; the winner drives a one-hot register write enable and the write data.
module rf_write_arbiter #(
  parameter int unsigned NREQ   = 3,
  parameter int unsigned DATA_W = 8
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   stall,
  input  logic [NREQ-1:0]        req,
  input  logic [3*NREQ-1:0]      req_reg,
  input  logic [DATA_W*NREQ-1:0] req_data,
  output logic [NREQ-1:0]        gnt,
  output logic [7:0]             wr_en_onehot,
  output logic [DATA_W-1:0]      wr_data,
  output logic [7:0]             conflict_cnt
);

  localparam int unsigned PTR_W = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int unsigned CNT_W = 4;

  logic [PTR_W-1:0]  ptr, ptr_nxt;
  logic [NREQ-1:0]   mask, mask_nxt;
  logic [NREQ-1:0]   gnt_nxt;
  logic [7:0]        wr_en_nxt;
  logic [DATA_W-1:0] wr_data_nxt;
  logic [7:0]        cnt_nxt;

  logic [NREQ-1:0]   elig_c;
  logic [CNT_W-1:0]  n_elig_c;
  logic              found_c;
  logic [PTR_W-1:0]  win_c;
  logic [2:0]        win_reg_c;
  int unsigned       idx;

  // Eligible set excludes the requester granted on the previous edge.
  always_comb begin
    elig_c   = req & ~mask;
    n_elig_c = '0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      n_elig_c = n_elig_c + CNT_W'(elig_c[i]);
    end
  end

  // First eligible requester scanning upward from ptr, wrapping.
  always_comb begin
    found_c = 1'b0;
    win_c   = '0;
    idx     = 0;
    for (int unsigned off = 0; off < NREQ; off++) begin
      idx = 32'(ptr) + off;
      if (idx >= NREQ) idx = idx - NREQ;
      if (!found_c && elig_c[idx]) begin
        found_c = 1'b1;
        win_c   = PTR_W'(idx);
      end
    end
    win_reg_c = req_reg[3*win_c +: 3];
  end

  // Next-state and registered-output values.
  always_comb begin
    gnt_nxt     = '0;
    wr_en_nxt   = '0;
    wr_data_nxt = wr_data;
    ptr_nxt     = ptr;
    mask_nxt    = '0;
    cnt_nxt     = conflict_cnt;
    if ((n_elig_c >= CNT_W'(2)) && (conflict_cnt != 8'hFF)) begin
      cnt_nxt = conflict_cnt + 8'd1;
    end
    if (!stall && found_c) begin
      gnt_nxt     = NREQ'(1) << win_c;
      wr_en_nxt   = 8'(1) << win_reg_c;
      wr_data_nxt = req_data[DATA_W*win_c +: DATA_W];
      mask_nxt    = NREQ'(1) << win_c;
      ptr_nxt     = (32'(win_c) == NREQ - 1) ? '0 : win_c + PTR_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      gnt          <= '0;
      wr_en_onehot <= '0;
      wr_data      <= '0;
      conflict_cnt <= '0;
      ptr          <= '0;
      mask         <= '0;
    end else begin
      gnt          <= gnt_nxt;
      wr_en_onehot <= wr_en_nxt;
      wr_data      <= wr_data_nxt;
      conflict_cnt <= cnt_nxt;
      ptr          <= ptr_nxt;
      mask         <= mask_nxt;
    end
  end

endmodule

// File: tb/tb_rf_write_arbiter.sv
// Self-checking bench for rf_write_arbiter: directed scenarios plus randomized traffic
// compared cycle by cycle against a behavioural round-robin model.
module tb_rf_write_arbiter;

  localparam int unsigned NREQ   = 3;
  localparam int unsigned DATA_W = 8;

  logic                   clk = 1'b0;
  logic                   reset;
  logic                   stall;
  logic [NREQ-1:0]        req;
  logic [3*NREQ-1:0]      req_reg;
  logic [DATA_W*NREQ-1:0] req_data;
  logic [NREQ-1:0]        gnt;
  logic [7:0]             wr_en_onehot;
  logic [DATA_W-1:0]      wr_data;
  logic [7:0]             conflict_cnt;

  int checks = 0;
  int errors = 0;

  // Reference model state
  int m_ptr, m_mask, m_cnt;
  int exp_gnt, exp_wren, exp_data;

  rf_write_arbiter #(.NREQ(NREQ), .DATA_W(DATA_W)) dut (
    .clk(clk), .reset(reset), .stall(stall), .req(req), .req_reg(req_reg),
    .req_data(req_data), .gnt(gnt), .wr_en_onehot(wr_en_onehot),
    .wr_data(wr_data), .conflict_cnt(conflict_cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s observed=%0h expected=%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Applies the arbitration rules to the inputs sampled at this edge.
  task automatic model_edge();
    int e, w, j, rc;
    bit found;
    if (reset) begin
      m_ptr = 0; m_mask = 0; m_cnt = 0;
      exp_gnt = 0; exp_wren = 0; exp_data = 0;
      return;
    end
    e = int'(req) & ~m_mask & ((1 << NREQ) - 1);
    if ($countones(e) >= 2 && m_cnt < 255) m_cnt++;
    found = 0;
    w = 0;
    if (!stall) begin
      for (int k = 0; k < NREQ; k++) begin
        j = (m_ptr + k) % NREQ;
        if (!found && e[j]) begin
          found = 1;
          w = j;
        end
      end
    end
    if (found) begin
      rc       = int'((req_reg >> (3 * w)) & 9'h7);
      exp_gnt  = 1 << w;
      exp_wren = 1 << rc;
      exp_data = int'((req_data >> (DATA_W * w)) & 24'hFF);
      m_ptr    = (w + 1) % NREQ;
      m_mask   = 1 << w;
    end else begin
      exp_gnt  = 0;
      exp_wren = 0;
      m_mask   = 0;
    end
  endtask

  task automatic cycle();
    @(posedge clk);
    model_edge();
    #1;
    check("gnt", 32'(gnt), 32'(exp_gnt));
    check("wr_en", 32'(wr_en_onehot), 32'(exp_wren));
    check("wr_data", 32'(wr_data), 32'(exp_data));
    check("conflict_cnt", 32'(conflict_cnt), 32'(m_cnt));
    check("gnt_onehot", 32'($countones(gnt) <= 1), 32'(1));
  endtask

  initial begin
    reset = 1'b1; stall = 1'b0; req = 3'b111;
    req_reg = {3'd3, 3'd2, 3'd1};
    req_data = {8'h33, 8'h22, 8'h11};

    // Reset held with all requesters asserted
    cycle(); cycle();
    check("t1_gnt_rst", 32'(gnt), 32'd0);
    check("t1_cnt_rst", 32'(conflict_cnt), 32'd0);
    reset = 1'b0;
    cycle();
    check("t1_first_gnt", 32'(gnt), 32'd1);

    // Single requester held two cycles: one grant only
    reset = 1'b1; cycle(); reset = 1'b0;
    req = 3'b001; req_reg = {3'd0, 3'd0, 3'd5}; req_data = {8'h00, 8'h00, 8'hA5};
    cycle();
    check("t2_gnt", 32'(gnt), 32'd1);
    check("t2_wren", 32'(wr_en_onehot), 32'h20);
    check("t2_data", 32'(wr_data), 32'hA5);
    cycle();
    check("t2_no_regrant", 32'(gnt), 32'd0);
    req = 3'b000; cycle();

    // All three requesting: rotation
    reset = 1'b1; cycle(); reset = 1'b0;
    req = 3'b111; req_reg = {3'd3, 3'd2, 3'd1}; req_data = {8'h33, 8'h22, 8'h11};
    for (int i = 0; i < 6; i++) begin
      cycle();
      check("t3_rot", 32'(gnt), 32'(1 << (i % 3)));
    end

    // Stall blocks grants
    req = 3'b110; stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      cycle();
      check("t4_stall", 32'(gnt), 32'd0);
    end
    stall = 1'b0;
    cycle(); check("t4_rel1", 32'(gnt), 32'b010);
    cycle(); check("t4_rel2", 32'(gnt), 32'b100);

    // Reset mid-operation drops the grant and resets the pointer
    stall = 1'b1; cycle(); stall = 1'b0;
    cycle(); check("t5_pre", 32'(gnt), 32'b010);
    reset = 1'b1; cycle(); reset = 1'b0;
    check("t5_rst_gnt", 32'(gnt), 32'd0);
    check("t5_rst_data", 32'(wr_data), 32'd0);
    req = 3'b011;
    cycle(); check("t5_after", 32'(gnt), 32'b001);

    // Alternation on two requesters
    for (int i = 0; i < 20; i++) cycle();

    // Randomized traffic with occasional stall and reset
    for (int i = 0; i < 2000; i++) begin
      req      = NREQ'($urandom);
      req_reg  = (3*NREQ)'($urandom);
      req_data = (DATA_W*NREQ)'($urandom);
      stall    = ($urandom_range(7) == 0);
      reset    = ($urandom_range(63) == 0);
      cycle();
    end

    // Saturation of the conflict counter
    reset = 1'b1; stall = 1'b0; cycle(); reset = 1'b0;
    req = 3'b111;
    for (int i = 0; i < 300; i++) cycle();
    check("t6_sat", 32'(conflict_cnt), 32'd255);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
